// File: rtl/uart_fifo_bridge_if.sv
// CPU-side valid/ready register bus used by uart_fifo_bridge.
interface uart_fifo_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffered UART front-end: RX/TX byte FIFOs between the CPU register bus
// and the uart core port, with STATUS/DATA/CTRL registers and an RX irq.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               r_clk,
  input  logic               rst_n,
  uart_fifo_bridge_if.slave  bus,
  output logic               u_we,
  output logic [31:0]        u_si,
  output logic               u_re,
  input  logic [31:0]        u_so,
  input  logic               u_wa,
  output logic               irq
);

  localparam logic [3:0]  ADDR_STATUS = 4'h0;
  localparam logic [3:0]  ADDR_DATA   = 4'h4;
  localparam logic [3:0]  ADDR_CTRL   = 4'h8;
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  // registered state
  logic          bus_ready_q, bus_ready_d;
  logic [31:0]   bus_rdata_q, bus_rdata_d;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          rx_ovf_q, rx_ovf_d, tx_ovr_q, tx_ovr_d;
  logic          irq_en_q, irq_en_d, irq_q, irq_d;
  state_e        rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic          u_re_q, u_re_d, u_we_q, u_we_d;
  logic [7:0]    u_si_q, u_si_d;

  // decoded events for the current cycle
  logic acc, is_wr, sel_status, sel_data, sel_ctrl;
  logic rx_nonempty, rx_full, tx_nonempty, tx_full;
  logic bus_rx_pop, bus_tx_push, ctrl_wr, stat_wr, rx_flush, tx_flush;
  logic rx_fsm_take, tx_fsm_pop;
  logic rx_push, rx_drop, tx_push, tx_drop;

  logic unused_wdata;
  assign unused_wdata = ^bus.bus_wdata[31:8];

  assign bus.bus_ready = bus_ready_q;
  assign bus.bus_rdata = bus_rdata_q;
  assign u_we          = u_we_q;
  assign u_si          = {24'h0, u_si_q};
  assign u_re          = u_re_q;
  assign irq           = irq_q;

  // Bus decode, FIFO bookkeeping, both uart-side FSMs and register updates.
  always_comb begin
    acc         = bus.bus_valid && !bus_ready_q;
    is_wr       = |bus.bus_wstrb;
    sel_status  = (bus.bus_addr == ADDR_STATUS);
    sel_data    = (bus.bus_addr == ADDR_DATA);
    sel_ctrl    = (bus.bus_addr == ADDR_CTRL);

    rx_nonempty = (rx_cnt_q != '0);
    rx_full     = (rx_cnt_q == FULL_CNT);
    tx_nonempty = (tx_cnt_q != '0);
    tx_full     = (tx_cnt_q == FULL_CNT);

    bus_rx_pop  = acc && !is_wr && sel_data && rx_nonempty;
    bus_tx_push = acc && is_wr && sel_data && bus.bus_wstrb[0];
    ctrl_wr     = acc && is_wr && sel_ctrl;
    stat_wr     = acc && is_wr && sel_status;
    rx_flush    = ctrl_wr && bus.bus_wdata[1];
    tx_flush    = ctrl_wr && bus.bus_wdata[2];

    rx_fsm_take = (rx_state_q == S_IDLE) && (u_so != '1);
    tx_fsm_pop  = (tx_state_q == S_IDLE) && tx_nonempty && !u_wa;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    // A concurrent flush discards the byte without flagging an overflow.
    rx_push = rx_fsm_take && (!rx_full || bus_rx_pop) && !rx_flush;
    rx_drop = rx_fsm_take && rx_full && !bus_rx_pop && !rx_flush;
    tx_push = bus_tx_push && (!tx_full || tx_fsm_pop) && !tx_flush;
    tx_drop = bus_tx_push && tx_full && !tx_fsm_pop && !tx_flush;

    // bus handshake and read mux
    bus_ready_d = acc;
    bus_rdata_d = '0;
    if (acc && !is_wr) begin
      unique case (bus.bus_addr)
        ADDR_STATUS: bus_rdata_d = {8'h0, 8'(tx_cnt_q), 8'(rx_cnt_q), 3'b000,
                                    tx_ovr_q, rx_ovf_q, !tx_nonempty, tx_full,
                                    rx_nonempty};
        ADDR_DATA:   bus_rdata_d = rx_nonempty ? {24'h0, rx_mem_q[rx_rp_q]} : '1;
        ADDR_CTRL:   bus_rdata_d = {31'h0, irq_en_q};
        default:     bus_rdata_d = '0;
      endcase
    end

    // RX FIFO
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_flush) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wp_q] = u_so[7:0];
        rx_wp_d           = rx_wp_q + AW'(1);
      end
      if (bus_rx_pop) begin
        rx_rp_d = rx_rp_q + AW'(1);
      end
      rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(bus_rx_pop);
    end

    // TX FIFO
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wp_q] = bus.bus_wdata[7:0];
        tx_wp_d           = tx_wp_q + AW'(1);
      end
      if (tx_fsm_pop) begin
        tx_rp_d = tx_rp_q + AW'(1);
      end
      tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_fsm_pop);
    end

    // sticky flags: a set event in the same cycle beats the clear
    rx_ovf_d = (rx_ovf_q && !(stat_wr && bus.bus_wdata[3])) || rx_drop;
    tx_ovr_d = (tx_ovr_q && !(stat_wr && bus.bus_wdata[4])) || tx_drop;
    irq_en_d = ctrl_wr ? bus.bus_wdata[0] : irq_en_q;
    irq_d    = irq_en_q && rx_nonempty;

    // RX fill FSM: acknowledge one byte, then give the core a cycle to advance
    rx_state_d = rx_state_q;
    u_re_d     = 1'b0;
    unique case (rx_state_q)
      S_IDLE: if (rx_fsm_take) begin
        u_re_d     = 1'b1;
        rx_state_d = S_HOLD;
      end
      S_HOLD: rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase

    // TX drain FSM: the head byte is latched into u_si before any flush lands
    tx_state_d = tx_state_q;
    u_we_d     = 1'b0;
    u_si_d     = u_si_q;
    unique case (tx_state_q)
      S_IDLE: if (tx_fsm_pop) begin
        u_we_d     = 1'b1;
        u_si_d     = tx_mem_q[tx_rp_q];
        tx_state_d = S_HOLD;
      end
      S_HOLD: tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  // FIFO storage, no reset needed since pointers and counts gate every read.
  always_ff @(posedge r_clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      bus_ready_q <= 1'b0;
      bus_rdata_q <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovr_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      rx_state_q  <= S_IDLE;
      tx_state_q  <= S_IDLE;
      u_re_q      <= 1'b0;
      u_we_q      <= 1'b0;
      u_si_q      <= '0;
    end else begin
      bus_ready_q <= bus_ready_d;
      bus_rdata_q <= bus_rdata_d;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovr_q    <= tx_ovr_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      u_re_q      <= u_re_d;
      u_we_q      <= u_we_d;
      u_si_q      <= u_si_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: register vector table, directed
// corner sequences, and randomized traffic against queue-based expectations.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        r_clk = 1'b0;
  logic        rst_n;
  logic        u_we, u_re, u_wa, irq;
  logic [31:0] u_si, u_so;

  uart_fifo_bridge_if bus_if ();

  uart_fifo_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .r_clk (r_clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .u_we  (u_we),
    .u_si  (u_si),
    .u_re  (u_re),
    .u_so  (u_so),
    .u_wa  (u_wa),
    .irq   (irq)
  );

  always #5 r_clk = ~r_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // uart core model: byte source for RX, byte sink for TX
  logic [7:0]  rx_feed[$];
  logic [7:0]  tx_seen[$];
  int unsigned we_count = 0;
  logic        prev_we  = 1'b0;
  logic        wa_cmd   = 1'b1;
  logic        wa_rand  = 1'b0;

  initial begin
    u_so = '1;
    u_wa = 1'b1;
  end

  always @(negedge r_clk) begin
    if (u_we === 1'b1) begin
      we_count++;
      tx_seen.push_back(u_si[7:0]);
      check("u_we_while_wa_low", {31'h0, u_wa}, 32'h0);
      check("u_we_single_cycle", {31'h0, prev_we}, 32'h0);
    end
    prev_we = u_we;
    if (u_re === 1'b1 && rx_feed.size() > 0) void'(rx_feed.pop_front());
    u_so = (rx_feed.size() > 0) ? {24'h0, rx_feed[0]} : 32'hFFFF_FFFF;
    u_wa = wa_rand ? ($urandom_range(0, 1) == 1) : wa_cmd;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge r_clk);
  endtask

  task automatic bus_xfer(input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
    logic rdy_first;
    @(negedge r_clk);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    bus_if.bus_wstrb = wstrb;
    @(posedge r_clk);
    #1;
    rdy_first = bus_if.bus_ready;
    rdata     = bus_if.bus_rdata;
    bus_if.bus_valid = 1'b0;
    bus_if.bus_wstrb = 4'h0;
    @(posedge r_clk);
    #1;
    check("bus_ready_pulse", {30'h0, rdy_first, bus_if.bus_ready}, 32'h2);
  endtask

  task automatic bus_wr(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_xfer(addr, wdata, 4'hF, dummy);
  endtask

  task automatic bus_rd(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(addr, 32'h0, 4'h0, rd);
    check(name, rd, exp);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_ref[$];
    int unsigned w0;
    int          n, m;

    vecs[0]  = '{4'h0, 32'h0,         4'h0, 1'b1, 32'h0000_0004};
    vecs[1]  = '{4'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[2]  = '{4'h4, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF};
    vecs[3]  = '{4'hC, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[4]  = '{4'h8, 32'h1,         4'hF, 1'b0, 32'h0};
    vecs[5]  = '{4'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0001};
    vecs[6]  = '{4'hC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{4'h0, 32'h0,         4'h0, 1'b1, 32'h0000_0004};
    vecs[8]  = '{4'h4, 32'h5A,        4'hF, 1'b0, 32'h0};
    vecs[9]  = '{4'h0, 32'h0,         4'h0, 1'b1, 32'h0001_0000};
    vecs[10] = '{4'h8, 32'h5,         4'hF, 1'b0, 32'h0};
    vecs[11] = '{4'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0001};
    vecs[12] = '{4'h0, 32'h0,         4'h0, 1'b1, 32'h0000_0004};
    vecs[13] = '{4'h8, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[14] = '{4'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[15] = '{4'h4, 32'h77,        4'h2, 1'b0, 32'h0};
    vecs[16] = '{4'h0, 32'h0,         4'h0, 1'b1, 32'h0000_0004};

    rst_n            = 1'b0;
    bus_if.bus_valid = 1'b0;
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;
    bus_if.bus_wstrb = 4'h0;
    wait_cycles(3);
    #1;
    check("reset_ctl_outputs", {28'h0, bus_if.bus_ready, u_we, u_re, irq}, 32'h0);
    check("reset_u_si", u_si, 32'h0);
    check("reset_rdata", bus_if.bus_rdata, 32'h0);
    @(negedge r_clk);
    rst_n = 1'b1;

    // register table with the core reporting busy, so nothing drains
    for (int i = 0; i < 17; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    check("no_we_while_busy", we_count, 32'd0);

    // TX ordering with the core idle
    wa_cmd = 1'b0;
    wait_cycles(2);
    tx_seen.delete();
    bus_wr(4'h4, 32'h41);
    bus_wr(4'h4, 32'h42);
    for (int c = 0; c < 50 && tx_seen.size() < 2; c++) @(posedge r_clk);
    check("tx_two_bytes", tx_seen.size(), 32'd2);
    if (tx_seen.size() == 2) begin
      check("tx_byte0", {24'h0, tx_seen[0]}, 32'h41);
      check("tx_byte1", {24'h0, tx_seen[1]}, 32'h42);
    end
    bus_rd("tx_drained_status", 4'h0, 32'h0000_0004);

    // RX path and irq
    rx_feed.push_back(8'h55);
    rx_feed.push_back(8'hAA);
    for (int c = 0; c < 50 && rx_feed.size() != 0; c++) @(posedge r_clk);
    check("rx_feed_consumed", rx_feed.size(), 32'd0);
    wait_cycles(3);
    bus_wr(4'h8, 32'h1);
    wait_cycles(1);
    check("irq_set", {31'h0, irq}, 32'h1);
    bus_rd("rx_read0", 4'h4, 32'h55);
    bus_rd("rx_read1", 4'h4, 32'hAA);
    bus_rd("rx_read_empty", 4'h4, 32'hFFFF_FFFF);
    wait_cycles(1);
    check("irq_clear", {31'h0, irq}, 32'h0);
    bus_wr(4'h8, 32'h0);

    // TX overrun while the core is busy
    wa_cmd = 1'b1;
    wait_cycles(2);
    w0 = we_count;
    for (int i = 0; i <= DEPTH; i++) bus_wr(4'h4, i);
    bus_rd("tx_full_status", 4'h0, (DEPTH << 16) | 32'h12);
    bus_wr(4'h0, 32'h10);
    bus_rd("tx_overrun_cleared", 4'h0, (DEPTH << 16) | 32'h02);
    bus_wr(4'h8, 32'h4);
    bus_rd("tx_flushed", 4'h0, 32'h0000_0004);
    check("no_we_during_overrun", we_count, w0);

    // RX overflow and flush
    for (int i = 0; i < DEPTH + 2; i++) rx_feed.push_back(8'(8'h80 + i));
    for (int c = 0; c < 200 && rx_feed.size() != 0; c++) @(posedge r_clk);
    check("rx_overflow_feed_consumed", rx_feed.size(), 32'd0);
    wait_cycles(3);
    bus_rd("rx_full_status", 4'h0, (DEPTH << 8) | 32'h0D);
    bus_wr(4'h8, 32'h2);
    bus_rd("rx_flushed_status", 4'h0, 32'h0000_000C);
    bus_wr(4'h0, 32'h8);
    bus_rd("rx_overflow_cleared", 4'h0, 32'h0000_0004);

    // reset in the middle of a TX drain
    for (int i = 0; i < 5; i++) bus_wr(4'h4, 32'hC0 + i);
    w0 = we_count;
    wa_cmd = 1'b0;
    for (int c = 0; c < 40 && we_count == w0; c++) @(posedge r_clk);
    check("drain_started", {31'h0, we_count > w0}, 32'h1);
    @(negedge r_clk);
    rst_n = 1'b0;
    @(posedge r_clk);
    #1;
    check("rst_mid_u_we", {31'h0, u_we}, 32'h0);
    check("rst_mid_u_si", u_si, 32'h0);
    @(negedge r_clk);
    rst_n = 1'b1;
    w0 = we_count;
    wait_cycles(30);
    check("no_we_after_reset", we_count, w0);
    bus_rd("status_after_reset", 4'h0, 32'h0000_0004);

    // randomized traffic against queue reference
    wa_rand = 1'b1;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, DEPTH);
      tx_seen.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_wr(4'h4, {$urandom, b} >> 0 & 32'hFFFF_FF00 | {24'h0, b});
        wait_cycles($urandom_range(0, 2));
      end
      for (int c = 0; c < 600 && tx_seen.size() < n; c++) @(posedge r_clk);
      check("rand_tx_count", tx_seen.size(), n);
      for (int k = 0; k < n; k++)
        check("rand_tx_order", (k < tx_seen.size()) ? {24'h0, tx_seen[k]} : 32'hDEAD_BEEF,
              {24'h0, exp_q[k]});

      m = $urandom_range(0, DEPTH);
      rx_ref.delete();
      for (int i = 0; i < m; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        rx_ref.push_back(b);
        @(negedge r_clk);
        rx_feed.push_back(b);
        wait_cycles($urandom_range(0, 3));
      end
      for (int c = 0; c < 400 && rx_feed.size() != 0; c++) @(posedge r_clk);
      check("rand_rx_feed_consumed", rx_feed.size(), 32'd0);
      wait_cycles(3);
      bus_xfer(4'h0, 32'h0, 4'h0, rd);
      check("rand_rx_count", (rd >> 8) & 32'hFF, m);
      for (int k = 0; k <= m; k++)
        bus_rd("rand_rx_data", 4'h4, (k < m) ? {24'h0, rx_ref[k]} : 32'hFFFF_FFFF);
    end
    wa_rand = 1'b0;
    wait_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
